// File: rtl/supersample_ctrl.sv
// Tile sequencer for the 4x4 -> 8x8 chroma upsampler: gathers raster-order
// pixels into a tile, launches the upsampler, then drains its 8x8 result row
// by row while the next tile is already filling.
module supersample_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_pixel,
    output logic                 us_valid_in,
    output logic [3:0][3:0][7:0] us_block,
    input  logic                 us_valid_out,
    input  logic [7:0][7:0][7:0] us_block_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [63:0]          out_row,
    output logic [2:0]           out_row_idx,
    output logic                 out_last,
    output logic                 busy,
    output logic                 err_timeout,
    output logic [CNT_W-1:0]     blocks_done
);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

    state_t                 state, state_nxt;
    logic [3:0]             fill_cnt;
    logic                   in_full;
    logic [3:0][3:0][7:0]   ibuf;
    logic [7:0][63:0]       obuf, obuf_nxt;
    logic [TMO_W-1:0]       tmo, tmo_nxt;
    logic                   us_valid_in_nxt;
    logic [3:0][3:0][7:0]   us_block_nxt;
    logic                   out_valid_nxt;
    logic [63:0]            out_row_nxt;
    logic [2:0]             out_row_idx_nxt;
    logic                   out_last_nxt;
    logic                   err_timeout_nxt;
    logic [CNT_W-1:0]       blocks_done_nxt;
    logic                   accept;
    logic                   launch;
    logic [2:0]             row_inc;

    assign in_ready = !in_full && !rst;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != S_IDLE) || (fill_cnt != 4'd0);
    assign row_inc  = out_row_idx + 3'd1;

    // Input tile buffer: raster fill, flagged full after the 16th pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt <= 4'd0;
            in_full  <= 1'b0;
        end else begin
            if (accept) begin
                ibuf[fill_cnt[3:2]][fill_cnt[1:0]] <= in_pixel;
                fill_cnt <= fill_cnt + 4'd1;
            end
            if (launch)
                in_full <= 1'b0;
            else if (accept && fill_cnt == 4'd15)
                in_full <= 1'b1;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            tmo         <= '0;
            obuf        <= '0;
            us_valid_in <= 1'b0;
            us_block    <= '0;
            out_valid   <= 1'b0;
            out_row     <= 64'd0;
            out_row_idx <= 3'd0;
            out_last    <= 1'b0;
            err_timeout <= 1'b0;
            blocks_done <= '0;
        end else begin
            state       <= state_nxt;
            tmo         <= tmo_nxt;
            obuf        <= obuf_nxt;
            us_valid_in <= us_valid_in_nxt;
            us_block    <= us_block_nxt;
            out_valid   <= out_valid_nxt;
            out_row     <= out_row_nxt;
            out_row_idx <= out_row_idx_nxt;
            out_last    <= out_last_nxt;
            err_timeout <= err_timeout_nxt;
            blocks_done <= blocks_done_nxt;
        end
    end

    // Launch / wait / drain sequencing
    always_comb begin
        state_nxt       = state;
        tmo_nxt         = tmo;
        obuf_nxt        = obuf;
        us_valid_in_nxt = us_valid_in;
        us_block_nxt    = us_block;
        out_valid_nxt   = out_valid;
        out_row_nxt     = out_row;
        out_row_idx_nxt = out_row_idx;
        out_last_nxt    = out_last;
        err_timeout_nxt = 1'b0;
        blocks_done_nxt = blocks_done;
        launch          = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_full) begin
                    launch          = 1'b1;
                    us_block_nxt    = ibuf;
                    us_valid_in_nxt = 1'b1;
                    tmo_nxt         = '0;
                    state_nxt       = S_WAIT;
                end
            end
            S_WAIT: begin
                if (us_valid_out) begin
                    // Row 0 is presented straight from the capture so it is valid next cycle
                    obuf_nxt        = us_block_out;
                    us_valid_in_nxt = 1'b0;
                    out_valid_nxt   = 1'b1;
                    out_row_nxt     = us_block_out[0];
                    out_row_idx_nxt = 3'd0;
                    out_last_nxt    = 1'b0;
                    state_nxt       = S_DRAIN;
                end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
                    tmo_nxt         = tmo + TMO_W'(1);
                    err_timeout_nxt = 1'b1;
                    us_valid_in_nxt = 1'b0;
                    state_nxt       = S_IDLE;
                end else begin
                    tmo_nxt = tmo + TMO_W'(1);
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (out_row_idx == 3'd7) begin
                        out_valid_nxt   = 1'b0;
                        out_last_nxt    = 1'b0;
                        blocks_done_nxt = blocks_done + CNT_W'(1);
                        state_nxt       = S_IDLE;
                    end else begin
                        out_row_idx_nxt = row_inc;
                        out_row_nxt     = obuf[row_inc];
                        out_last_nxt    = (row_inc == 3'd7);
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_supersample_ctrl.sv
// Directed bench for supersample_ctrl with a pixel-replicating upsampler model
// whose answer arrives a programmable number of cycles after launch.
module tb_supersample_ctrl;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CNT_W   = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [7:0]           in_pixel;
    logic                 us_valid_in;
    logic [3:0][3:0][7:0] us_block;
    logic                 us_valid_out;
    logic [7:0][7:0][7:0] us_block_out;
    logic                 out_valid;
    logic                 out_ready;
    logic [63:0]          out_row;
    logic [2:0]           out_row_idx;
    logic                 out_last;
    logic                 busy;
    logic                 err_timeout;
    logic [CNT_W-1:0]     blocks_done;

    supersample_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .us_valid_in(us_valid_in), .us_block(us_block), .us_valid_out(us_valid_out),
        .us_block_out(us_block_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_row_idx(out_row_idx), .out_last(out_last), .busy(busy),
        .err_timeout(err_timeout), .blocks_done(blocks_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] row;
        logic [2:0]  idx;
        logic        last;
        int          cyc;
    } rec_t;

    typedef struct {
        logic [7:0]  base;
        int          delay;
        bit          toggle;
        logic [63:0] row0;
        logic [63:0] row7;
    } vec_t;

    // Stimulus controls owned by the main sequence
    int         us_delay = 0;
    logic       rdy_val  = 1'b1;
    logic       rdy_tog  = 1'b0;
    logic [7:0] pix_q[$];

    // Observations gathered at the falling edge
    rec_t        rec_q[$];
    int          cyc = 0;
    int          us_cnt = 0;
    int          acc_cnt = 0, acc16_cyc = 0, rise_cyc = 0, ov_rise_cyc = 0, err_cyc = 0;
    int          err_cnt = 0, ov_cnt = 0, uvi_hi = 0;
    int          ir_viol = 0, blk_viol = 0, stall_viol = 0;
    logic        fm = 1'b0, pend = 1'b0, prev_uvi = 1'b0, prev_ov = 1'b0;
    logic        prev_stall = 1'b0, in_hs = 1'b0;
    logic [63:0] prev_row = '0;
    logic [2:0]  prev_idx = '0;
    logic [127:0] prev_blk = '0, rise_blk = '0;
    logic        cur_full;

    int n_chk = 0, n_fail = 0;

    // Upsampler model: each output pixel replicates its 2x2 source pixel
    always_comb begin
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                us_block_out[i][j] = us_block[i >> 1][j >> 1];
    end
    assign us_valid_out = us_valid_in && (us_cnt > us_delay);

    always @(negedge clk) us_cnt <= us_valid_in ? us_cnt + 1 : 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected input-buffer-full state after the most recent edge
    assign cur_full = (fm || pend) && !(us_valid_in && !prev_uvi);

    // Monitor: handshakes, launch/timeout events and stability properties
    always @(negedge clk) begin
        if (rst) begin
            fm <= 1'b0; pend <= 1'b0; acc_cnt <= 0; prev_uvi <= 1'b0;
            prev_ov <= 1'b0; prev_stall <= 1'b0; in_hs <= 1'b0;
        end else begin
            if (in_ready !== !cur_full) ir_viol <= ir_viol + 1;
            in_hs <= in_valid && in_ready;
            if (in_valid && in_ready) begin
                acc_cnt <= acc_cnt + 1;
                if (acc_cnt % 16 == 15) acc16_cyc <= cyc;
            end
            pend <= in_valid && in_ready && (acc_cnt % 16 == 15);
            fm   <= cur_full;
            if (us_valid_in && !prev_uvi) begin
                rise_cyc <= cyc;
                rise_blk <= us_block;
            end
            if (us_valid_in && prev_uvi && us_block !== prev_blk) blk_viol <= blk_viol + 1;
            if (us_valid_in) uvi_hi <= uvi_hi + 1;
            if (out_valid && !prev_ov) ov_rise_cyc <= cyc;
            if (out_valid) ov_cnt <= ov_cnt + 1;
            if (prev_stall && (out_row !== prev_row || out_row_idx !== prev_idx || out_valid !== 1'b1))
                stall_viol <= stall_viol + 1;
            prev_stall <= out_valid && !out_ready;
            prev_row   <= out_row;
            prev_idx   <= out_row_idx;
            if (out_valid && out_ready) rec_q.push_back('{out_row, out_row_idx, out_last, cyc});
            if (err_timeout) begin
                err_cnt <= err_cnt + 1;
                err_cyc <= cyc;
            end
            prev_uvi <= us_valid_in;
            prev_ov  <= out_valid;
            prev_blk <= us_block;
        end
    end

    // Pixel feeder and out_ready driver, updated just after each rising edge
    initial begin
        in_valid  = 1'b0;
        in_pixel  = 8'd0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (in_hs && pix_q.size() > 0) void'(pix_q.pop_front());
            in_valid  = (pix_q.size() > 0);
            in_pixel  = (pix_q.size() > 0) ? pix_q[0] : 8'd0;
            out_ready = rdy_tog ? !out_ready : rdy_val;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] exp_row(input logic [7:0] b, input int r);
        logic [63:0] v;
        v = '0;
        for (int j = 0; j < 8; j++) v[8*j +: 8] = b + 8'((r >> 1) * 4 + (j >> 1));
        return v;
    endfunction

    function automatic logic [127:0] exp_tile(input logic [7:0] b);
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[8*k +: 8] = b + 8'(k);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push_tile(input logic [7:0] b);
        for (int k = 0; k < 16; k++) pix_q.push_back(b + 8'(k));
    endtask

    task automatic wait_blocks(input string nm, input int n, input int budget);
        int k;
        k = 0;
        while (blocks_done != CNT_W'(n) && k < budget) begin
            tick();
            k++;
        end
        chk(nm, blocks_done, n);
    endtask

    task automatic check_block(input string nm, input logic [7:0] b, input int first);
        if (rec_q.size() < first + 8) begin
            chk({nm, "_count"}, rec_q.size(), first + 8);
            return;
        end
        for (int r = 0; r < 8; r++)
            chk($sformatf("%s_row%0d", nm, r),
                {rec_q[first+r].last, rec_q[first+r].idx, rec_q[first+r].row},
                {(r == 7), 3'(r), exp_row(b, r)});
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {in_ready, us_valid_in, us_block, out_valid, out_row, out_row_idx,
                 out_last, busy, err_timeout, blocks_done}, '0);
    endtask

    initial begin
        vec_t vecs[4];
        int   b0, u0, bv0, sv0, iv0, e0, o0, a0, k;

        vecs[0] = '{8'h00, 0, 1'b0, 64'h0303020201010000, 64'h0F0F0E0E0D0D0C0C};
        vecs[1] = '{8'h10, 2, 1'b1, 64'h1313121211111010, 64'h1F1F1E1E1D1D1C1C};
        vecs[2] = '{8'hF0, 5, 1'b0, 64'hF3F3F2F2F1F1F0F0, 64'hFFFFFEFEFDFDFCFC};
        vecs[3] = '{8'hA5, 1, 1'b1, 64'hA8A8A7A7A6A6A5A5, 64'hB4B4B3B3B2B2B1B1};

        rst = 1'b1;
        tick();
        tick();
        chk_all_zero("reset_state");
        rst = 1'b0;

        // Single tiles: data, row 0/7 hand values, launch and capture latency
        for (int v = 0; v < 4; v++) begin
            do_reset();
            us_delay = vecs[v].delay;
            rdy_tog  = vecs[v].toggle;
            rdy_val  = 1'b1;
            b0 = rec_q.size(); u0 = uvi_hi; bv0 = blk_viol; sv0 = stall_viol; iv0 = ir_viol;
            push_tile(vecs[v].base);
            wait_blocks($sformatf("v%0d_done", v), 1, 200);
            if (rec_q.size() >= b0 + 8) begin
                chk($sformatf("v%0d_row0", v), {rec_q[b0].idx, rec_q[b0].row}, {3'd0, vecs[v].row0});
                chk($sformatf("v%0d_row7", v), {rec_q[b0+7].last, rec_q[b0+7].row}, {1'b1, vecs[v].row7});
            end
            check_block($sformatf("v%0d", v), vecs[v].base, b0);
            chk($sformatf("v%0d_tile", v), rise_blk, exp_tile(vecs[v].base));
            chk($sformatf("v%0d_launch_lat", v), rise_cyc - acc16_cyc, 2);
            chk($sformatf("v%0d_capture_lat", v), ov_rise_cyc - rise_cyc, vecs[v].delay + 1);
            chk($sformatf("v%0d_uvi_cycles", v), uvi_hi - u0, vecs[v].delay + 1);
            chk($sformatf("v%0d_blk_stable", v), blk_viol - bv0, 0);
            chk($sformatf("v%0d_hold", v), stall_viol - sv0, 0);
            chk($sformatf("v%0d_in_ready", v), ir_viol - iv0, 0);
            chk($sformatf("v%0d_busy", v), busy, 0);
        end

        // Two tiles streamed back to back with out_ready toggling
        do_reset();
        us_delay = 0; rdy_tog = 1'b1;
        b0 = rec_q.size(); sv0 = stall_viol; iv0 = ir_viol;
        push_tile(8'h20);
        push_tile(8'h30);
        wait_blocks("str_done", 2, 300);
        check_block("str_t1", 8'h20, b0);
        check_block("str_t2", 8'h30, b0 + 8);
        chk("str_hold", stall_viol - sv0, 0);
        chk("str_in_ready", ir_viol - iv0, 0);

        // Upsampler never answers in time: block dropped, then recovery
        do_reset();
        us_delay = int'(TIMEOUT) + 2; rdy_tog = 1'b0; rdy_val = 1'b1;
        e0 = err_cnt; o0 = ov_cnt;
        push_tile(8'h40);
        k = 0;
        while (err_cnt == e0 && k < 80) begin
            tick();
            k++;
        end
        chk("to_seen", err_cnt - e0, 1);
        chk("to_delay", err_cyc - rise_cyc, TIMEOUT);
        repeat (10) tick();
        chk("to_single", err_cnt - e0, 1);
        chk("to_no_out", ov_cnt - o0, 0);
        chk("to_idle", {us_valid_in, busy, blocks_done}, 0);
        us_delay = 3;
        b0 = rec_q.size();
        push_tile(8'h50);
        wait_blocks("to_next_done", 1, 200);
        check_block("to_next", 8'h50, b0);
        chk("to_next_lat", ov_rise_cyc - rise_cyc, 4);

        // Second tile fills while the first is stalled at the output
        do_reset();
        us_delay = 0; rdy_tog = 1'b0; rdy_val = 1'b0;
        b0 = rec_q.size(); iv0 = ir_viol;
        push_tile(8'h90);
        push_tile(8'hA0);
        k = 0;
        while (acc_cnt < 32 && k < 100) begin
            tick();
            k++;
        end
        chk("ovl_acc32", acc_cnt, 32);
        repeat (20) tick();
        chk("ovl_stall", {in_ready, out_valid, out_row_idx, out_row},
            {1'b0, 1'b1, 3'd0, exp_row(8'h90, 0)});
        rdy_val = 1'b1;
        wait_blocks("ovl_done", 2, 100);
        check_block("ovl_t1", 8'h90, b0);
        check_block("ovl_t2", 8'hA0, b0 + 8);
        if (rec_q.size() >= b0 + 8) chk("ovl_relaunch", rise_cyc - rec_q[b0+7].cyc, 2);
        chk("ovl_in_ready", ir_viol - iv0, 0);

        // Reset with a partial tile, then reset mid-drain at row 3
        rdy_tog = 1'b0; rdy_val = 1'b1;
        a0 = acc_cnt;
        for (int p = 0; p < 9; p++) pix_q.push_back(8'hC0 + 8'(p));
        k = 0;
        while (acc_cnt < a0 + 9 && k < 40) begin
            tick();
            k++;
        end
        chk("rst9_acc", acc_cnt - a0, 9);
        rst = 1'b1;
        tick();
        chk_all_zero("rst9_outputs");
        rst = 1'b0;
        b0 = rec_q.size();
        push_tile(8'h60);
        wait_blocks("rst9_done", 1, 200);
        check_block("rst9_blk", 8'h60, b0);
        push_tile(8'h70);
        k = 0;
        while (!(out_valid && out_row_idx == 3'd3) && k < 100) begin
            tick();
            k++;
        end
        chk("rstmid_row3", {out_valid, out_row_idx}, {1'b1, 3'd3});
        rst = 1'b1;
        tick();
        chk_all_zero("rstmid_outputs");
        rst = 1'b0;
        b0 = rec_q.size();
        push_tile(8'h80);
        wait_blocks("rstmid_done", 1, 200);
        check_block("rstmid_blk", 8'h80, b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
